// File: rtl/ddr4_cmd_scheduler.sv
// DDR4 command sequencer: one read/write request at a time becomes PRE/ACT/RD/WR
// with open-page row tracking, per-bank tRAS/tWR timers and data-window strobes.
module ddr4_cmd_scheduler #(
  parameter int RANKS     = 1,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TINIT     = 5,
  parameter int TRCD      = 15,
  parameter int TCL       = 15,
  parameter int TCWL      = 12,
  parameter int TRP       = 15,
  parameter int TRAS      = 36,
  parameter int TWR       = 18,
  localparam int RW       = (RANKS > 1) ? $clog2(RANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [RW-1:0]        req_rank,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 cke,
  output logic [RANKS-1:0]     cs_n,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 odt,
  output logic                 parity,
  output logic                 wr_en,
  output logic                 rd_valid,
  output logic                 done
);

  localparam int BW  = RW + BGWIDTH + BAWIDTH;
  localparam int NB  = 1 << BW;
  localparam int TCW = $clog2(((TRAS > TWR) ? TRAS : TWR) + 1);
  localparam int WCW = 16;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_CAS, S_DATA_LAT, S_BURST
  } state_t;

  state_t         state, state_d;
  logic [WCW-1:0] cnt, cnt_d;

  logic                 we_q;
  logic [RW-1:0]        rank_q;
  logic [BGWIDTH-1:0]   bg_q;
  logic [BAWIDTH-1:0]   ba_q;
  logic [ADDRWIDTH-1:0] row_q;
  logic [COLWIDTH-1:0]  col_q;

  logic                 open_v   [NB];
  logic [ADDRWIDTH-1:0] open_row [NB];
  logic [TCW-1:0]       ras_cnt  [NB];
  logic [TCW-1:0]       wr_cnt   [NB];

  logic [BW-1:0] bank_in, bank_q;
  assign bank_in = {req_rank, req_bg, req_ba};
  assign bank_q  = {rank_q, bg_q, ba_q};

  logic                 latch, issue_pre, issue_act, issue_cas, data_on, wr_end;
  logic                 cke_d, ready_d, done_d, act_n_d;
  logic [RANKS-1:0]     cs_n_d;
  logic [ADDRWIDTH-1:0] a_d;
  logic [BGWIDTH-1:0]   bg_d;
  logic [BAWIDTH-1:0]   ba_d;
  logic [WCW-1:0]       cas_lat;

  assign cas_lat = we_q ? WCW'(TCWL - 1) : WCW'(TCL - 1);

  // Outputs are computed here one cycle ahead and registered, so every wait
  // state issues the following command itself when its count expires.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cke_d     = cke;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    latch     = 1'b0;
    issue_pre = 1'b0;
    issue_act = 1'b0;
    issue_cas = 1'b0;
    data_on   = 1'b0;
    wr_end    = 1'b0;
    unique case (state)
      S_INIT: begin
        if (cnt == '0) begin
          cke_d   = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - WCW'(1);
        end
      end
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && req_ready) begin
          ready_d = 1'b0;
          latch   = 1'b1;
          if (!open_v[bank_in])                     state_d = S_ACT;
          else if (open_row[bank_in] == req_row)    state_d = S_CAS;
          else                                      state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (ras_cnt[bank_q] >= TCW'(TRAS) && wr_cnt[bank_q] >= TCW'(TWR)) begin
          issue_pre = 1'b1;
          cnt_d     = WCW'(TRP - 1);
          state_d   = S_PRE_WAIT;
        end
      end
      S_PRE_WAIT: begin
        if (cnt == '0) begin
          issue_act = 1'b1;
          cnt_d     = WCW'(TRCD - 1);
          state_d   = S_ACT_WAIT;
        end else begin
          cnt_d = cnt - WCW'(1);
        end
      end
      S_ACT: begin
        issue_act = 1'b1;
        cnt_d     = WCW'(TRCD - 1);
        state_d   = S_ACT_WAIT;
      end
      S_ACT_WAIT: begin
        if (cnt == '0) begin
          issue_cas = 1'b1;
          cnt_d     = cas_lat;
          state_d   = S_DATA_LAT;
        end else begin
          cnt_d = cnt - WCW'(1);
        end
      end
      S_CAS: begin
        issue_cas = 1'b1;
        cnt_d     = cas_lat;
        state_d   = S_DATA_LAT;
      end
      S_DATA_LAT: begin
        if (cnt == '0) begin
          data_on = 1'b1;
          cnt_d   = WCW'(BL - 1);
          state_d = S_BURST;
        end else begin
          cnt_d = cnt - WCW'(1);
        end
      end
      S_BURST: begin
        if (cnt == '0) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          wr_end  = we_q;
          state_d = S_IDLE;
        end else begin
          data_on = 1'b1;
          cnt_d   = cnt - WCW'(1);
        end
      end
      default: state_d = S_INIT;
    endcase

    cs_n_d  = '1;
    act_n_d = 1'b1;
    a_d     = '0;
    bg_d    = '0;
    ba_d    = '0;
    if (issue_pre || issue_act || issue_cas) begin
      for (int unsigned i = 0; i < RANKS; i++) begin
        if (rank_q == RW'(i)) cs_n_d[i] = 1'b0;
      end
      bg_d = bg_q;
      ba_d = ba_q;
    end
    if (issue_act) begin
      act_n_d = 1'b0;
      a_d     = row_q;
    end
    if (issue_pre) a_d[16:14] = 3'b010;
    if (issue_cas) begin
      a_d[16:14]         = we_q ? 3'b100 : 3'b101;
      a_d[COLWIDTH-1:0]  = col_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      cnt       <= WCW'(TINIT);
      cke       <= 1'b0;
      cs_n      <= '1;
      act_n     <= 1'b1;
      A         <= '0;
      bg        <= '0;
      ba        <= '0;
      odt       <= 1'b0;
      parity    <= 1'b0;
      req_ready <= 1'b0;
      wr_en     <= 1'b0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      we_q      <= 1'b0;
      rank_q    <= '0;
      bg_q      <= '0;
      ba_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      for (int unsigned b = 0; b < NB; b++) begin
        open_v[b]   <= 1'b0;
        open_row[b] <= '0;
        ras_cnt[b]  <= TCW'(TRAS);
        wr_cnt[b]   <= TCW'(TWR);
      end
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cke       <= cke_d;
      cs_n      <= cs_n_d;
      act_n     <= act_n_d;
      A         <= a_d;
      bg        <= bg_d;
      ba        <= ba_d;
      odt       <= data_on && we_q;
      wr_en     <= data_on && we_q;
      rd_valid  <= data_on && !we_q;
      parity    <= ^{act_n_d, a_d, bg_d, ba_d};
      req_ready <= ready_d;
      done      <= done_d;
      if (latch) begin
        we_q   <= req_we;
        rank_q <= req_rank;
        bg_q   <= req_bg;
        ba_q   <= req_ba;
        row_q  <= req_row;
        col_q  <= req_col;
      end
      // Timers hold "cycles since event" and saturate once the constraint is met.
      for (int unsigned b = 0; b < NB; b++) begin
        if (issue_act && bank_q == BW'(b)) begin
          open_v[b]   <= 1'b1;
          open_row[b] <= row_q;
          ras_cnt[b]  <= TCW'(1);
        end else begin
          if (issue_pre && bank_q == BW'(b)) open_v[b] <= 1'b0;
          if (ras_cnt[b] < TCW'(TRAS)) ras_cnt[b] <= ras_cnt[b] + TCW'(1);
        end
        if (wr_end && bank_q == BW'(b))  wr_cnt[b] <= TCW'(1);
        else if (wr_cnt[b] < TCW'(TWR))  wr_cnt[b] <= wr_cnt[b] + TCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Bench for ddr4_cmd_scheduler: an event-time model predicts PRE/ACT/CAS cycles,
// data windows and done per request; every cycle's pins are compared against it.
module tb_ddr4_cmd_scheduler;

  localparam int RANKS = 1, BGWIDTH = 2, BAWIDTH = 2, ADDRWIDTH = 17, COLWIDTH = 10;
  localparam int BL = 8, TINIT = 5, TRCD = 15, TCL = 15, TCWL = 12;
  localparam int TRP = 15, TRAS = 36, TWR = 18;
  localparam int NB = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_we = 1'b0;
  logic [0:0]           req_rank = '0;
  logic [BGWIDTH-1:0]   req_bg = '0;
  logic [BAWIDTH-1:0]   req_ba = '0;
  logic [ADDRWIDTH-1:0] req_row = '0;
  logic [COLWIDTH-1:0]  req_col = '0;
  logic                 req_ready, cke, act_n, odt, parity, wr_en, rd_valid, done;
  logic [RANKS-1:0]     cs_n;
  logic [ADDRWIDTH-1:0] A;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;

  ddr4_cmd_scheduler #(
    .RANKS(RANKS), .BGWIDTH(BGWIDTH), .BAWIDTH(BAWIDTH), .ADDRWIDTH(ADDRWIDTH),
    .COLWIDTH(COLWIDTH), .BL(BL), .TINIT(TINIT), .TRCD(TRCD), .TCL(TCL),
    .TCWL(TCWL), .TRP(TRP), .TRAS(TRAS), .TWR(TWR)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_rank(req_rank), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_col(req_col), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .A(A), .bg(bg), .ba(ba), .odt(odt), .parity(parity), .wr_en(wr_en),
    .rd_valid(rd_valid), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_pins(input logic e_cke, input logic e_ready, input logic e_done,
                            input logic e_wr, input logic e_rd, input logic e_cs,
                            input logic e_act_n, input logic [16:0] e_a,
                            input logic [1:0] e_bg, input logic [1:0] e_ba,
                            input logic in_rst);
    logic e_par;
    e_par = in_rst ? 1'b0 : ^{e_act_n, e_a, e_bg, e_ba};
    check_eq("ctl",    {29'd0, cke, req_ready, done}, {29'd0, e_cke, e_ready, e_done});
    check_eq("data",   {29'd0, wr_en, odt, rd_valid}, {29'd0, e_wr, e_wr, e_rd});
    check_eq("cmd",    {9'd0, cs_n, act_n, A, bg, ba}, {9'd0, e_cs, e_act_n, e_a, e_bg, e_ba});
    check_eq("parity", {31'd0, parity}, {31'd0, e_par});
  endtask

  task automatic idle_check();
    check_pins(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 17'd0, 2'd0, 2'd0, 1'b0);
  endtask

  // Reference model: per-bank open row, time of last ACT, time of last write completion.
  bit mopen     [NB];
  int mrow      [NB];
  int mlast_act [NB];
  int mlast_wd  [NB];

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      mopen[i]     = 1'b0;
      mrow[i]      = 0;
      mlast_act[i] = -100000;
      mlast_wd[i]  = -100000;
    end
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  task automatic do_reset(input int hold);
    rst = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 17'd0, 2'd0, 2'd0, 1'b1);
    end
    rst = 1'b0;
    for (int k = 1; k <= TINIT + 1; k++) begin
      @(negedge clk);
      check_pins(k == TINIT + 1, k == TINIT + 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 17'd0, 2'd0, 2'd0, 1'b0);
    end
    model_reset();
  endtask

  // Entered at a negedge with the scheduler idle; returns at the negedge of done
  // (or after abort_at cycles past the accept edge when abort_at > 0).
  task automatic run_req(input logic we, input logic [1:0] rbg, input logic [1:0] rba,
                         input int row, input int col, input int gap, input int abort_at);
    int t0, b, t_pre, t_act, t_cas, t_ds, t_done, lim, t;
    logic [16:0] e_a;
    logic        e_act_n, e_cmd;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      idle_check();
    end
    req_valid = 1'b1;
    req_we    = we;
    req_rank  = 1'b0;
    req_bg    = rbg;
    req_ba    = rba;
    req_row   = 17'(row);
    req_col   = 10'(col);
    @(negedge clk);
    t0 = cyc;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_bg    = 2'($urandom);
    req_ba    = 2'($urandom);
    req_row   = 17'($urandom);
    req_col   = 10'($urandom);

    b     = int'({1'b0, rbg, rba});
    t_pre = -1;
    t_act = -1;
    if (mopen[b] && mrow[b] == row) begin
      t_cas = t0 + 1;
    end else if (!mopen[b]) begin
      t_act = t0 + 1;
      t_cas = t_act + TRCD;
    end else begin
      t_pre = max3(t0 + 1, mlast_act[b] + TRAS, mlast_wd[b] + TWR);
      t_act = t_pre + TRP;
      t_cas = t_act + TRCD;
    end
    t_ds   = t_cas + (we ? TCWL : TCL);
    t_done = t_ds + BL;
    mopen[b] = 1'b1;
    mrow[b]  = row;
    if (t_act >= 0) mlast_act[b] = t_act;
    if (we) mlast_wd[b] = t_done;

    lim = (abort_at > 0) ? t0 + abort_at : t_done;
    t = t0;
    while (1) begin
      e_act_n = 1'b1;
      e_a     = 17'd0;
      e_cmd   = 1'b0;
      if (t == t_pre) begin
        e_a   = 17'h08000;
        e_cmd = 1'b1;
      end
      if (t == t_act) begin
        e_act_n = 1'b0;
        e_a     = 17'(row);
        e_cmd   = 1'b1;
      end
      if (t == t_cas) begin
        e_a   = (we ? 17'h10000 : 17'h14000) | 17'(col);
        e_cmd = 1'b1;
      end
      check_pins(1'b1, t == t_done, t == t_done,
                 we && t >= t_ds && t < t_ds + BL, !we && t >= t_ds && t < t_ds + BL,
                 !e_cmd, e_act_n, e_a, e_cmd ? rbg : 2'd0, e_cmd ? rba : 2'd0, 1'b0);
      if (t >= lim) break;
      @(negedge clk);
      t = cyc;
    end
  endtask

  initial begin
    do_reset(3);
    run_req(1'b0, 2'd1, 2'd1, 1, 0, 0, 0);
    run_req(1'b1, 2'd1, 2'd1, 1, 0, 0, 0);
    run_req(1'b0, 2'd1, 2'd1, 2, 0, 0, 0);
    repeat (40) begin
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 3)), 0);
    end
    // Reset lands in the ACT-to-CAS wait; the bank must come back closed.
    run_req(1'b0, 2'd2, 2'd3, 5, 7, 1, 6);
    do_reset(1);
    run_req(1'b0, 2'd2, 2'd3, 5, 7, 0, 0);
    repeat (3) begin
      @(negedge clk);
      idle_check();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr4_cmd_scheduler.md
Name: ddr4_cmd_scheduler

Overview:
Single-requester DDR4 command sequencer that drives the command/address pins of the emulated `dimm`. It turns one read/write request at a time into legal PRE/ACT/RD/WR sequences. It tracks the open row of every bank per rank under an open-page policy and enforces tRP, tRCD, tRAS, tWR, CL and CWL. It also generates the data-window strobes the host datapath uses to drive or sample dq.

Parameters:
RANKS, 1, number of ranks (one cs_n bit each)
BGWIDTH, 2, bank-group address bits
BAWIDTH, 2, bank address bits
ADDRWIDTH, 17, row address width (A pins)
COLWIDTH, 10, column address width
BL, 8, burst length in cycles
TINIT, 5, cycles with cke low after reset
TRCD, 15, ACT to RD/WR, cycles
TCL, 15, RD to first read data cycle
TCWL, 12, WR to first write data cycle
TRP, 15, PRE to ACT, cycles
TRAS, 36, ACT to PRE minimum, cycles
TWR, 18, end of write data to PRE, cycles

Ports:
clk  in  1  clock (one command slot per cycle)
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  scheduler accepts request this cycle
req_we  in  1  1 = write, 0 = read
req_rank  in  max(1,$clog2(RANKS))  target rank
req_bg  in  BGWIDTH  bank group
req_ba  in  BAWIDTH  bank
req_row  in  ADDRWIDTH  row
req_col  in  COLWIDTH  column
cke  out  1  clock enable
cs_n  out  RANKS  chip selects, active low
act_n  out  1  activate strobe
A  out  ADDRWIDTH  address / command bits (A16=RAS_n, A15=CAS_n, A14=WE_n when act_n=1)
bg  out  BGWIDTH  bank group
ba  out  BAWIDTH  bank
odt  out  1  on-die termination
parity  out  1  even parity over act_n, A, bg, ba
wr_en  out  1  host drives write data on dq this cycle
rd_valid  out  1  read data valid on dq this cycle
done  out  1  one-cycle pulse when request completes

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. All outputs are registered.
- Reset values: cke=0, cs_n=all 1, act_n=1, A=0, bg=0, ba=0, odt=0, parity=0, req_ready=0, wr_en=0, rd_valid=0, done=0. All open-row valid bits are cleared. FSM enters INIT.
- A reset asserted mid-operation aborts immediately: reset values apply the next cycle and no further command or data strobe is issued.
- INIT: hold cke=0 for TINIT cycles, then set cke=1 and go to IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready at edge T, latch the request and drop req_ready. req_ready is high only in IDLE.
- Decision on the latched request (bank index = {rank,bg,ba}):
  - Row hit (open and row equal): go to CAS.
  - Bank closed: go to ACT.
  - Row conflict: go to PRE.
- PRE: wait until tRAS (cycles since last ACT to that bank ≥ TRAS) and tWR (≥ TWR since last write-data end on that bank) are both met. Then issue PRE for one cycle: act_n=1, A16..14=010, A10=0, bg/ba set. Clear the bank's valid bit. Wait TRP cycles, then go to ACT.
- ACT: act_n=0, A=row for one cycle. Set the bank's valid bit and row. Restart the bank's tRAS counter. Wait TRCD cycles, then go to CAS.
- CAS: act_n=1, A16..14=101 (RD) or 100 (WR), A[COLWIDTH-1:0]=col, other A bits 0, for one cycle.
- Data window starts TCL (read) or TCWL (write) cycles after the CAS cycle and lasts exactly BL cycles:
  - rd_valid=1 on read cycles.
  - wr_en=1 and odt=1 on write cycles.
- done pulses the cycle after the last data cycle. The FSM is in IDLE with req_ready=1 in that same cycle.
- Non-command cycles: selected cs_n bit = 1 (deselect), act_n=1, A=0.
- During a command cycle only cs_n[req_rank]=0.
- parity is computed on every cycle's outputs.
- Latency, from accept edge T with all timing satisfied:
  - Hit: CAS at T+1.
  - Closed: ACT at T+1, CAS at T+1+TRCD.
  - Conflict: PRE at T+1, ACT at T+1+TRP, CAS at T+1+TRP+TRCD.
- Timing counters saturate and do not wrap. At reset, counters start at the satisfied state.
- Simultaneous req_valid while busy is ignored; the requester must hold the request until it is accepted.

Test Plan:
- Reset then idle → cke=0 for 5 cycles, cke=1 on cycle 6, req_ready=1; all other outputs at reset values.
- Read rank0 bg1 ba1 row 1 col 0 to a closed bank, accepted at T → act_n=0 with A=1 at T+1; A=0x14000 at T+16; rd_valid high T+31..T+38; done at T+39.
- Write to the same row (hit), accepted at T → A=0x10000 at T+1; wr_en and odt high T+13..T+20; done at T+21.
- Read same bank row 2 (conflict) immediately after the write → PRE (A=0x08000, bg=1, ba=1) delayed until both TRAS since the ACT and TWR=18 after write end are met. ACT row 2 follows TRP later, then RD TRCD later.
- Assert rst during ACT_WAIT → next cycle all outputs at reset values, no CAS issued, INIT reruns. A following request to the same bank issues ACT, not a row hit.
- Parity check on every command → parity equals XOR of act_n, A, bg, ba; e.g. 1 for ACT with row 1, bg1, ba1.
